// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for an in-order five-stage pipeline. It resolves
// data hazards with operand forwarding and load-use bubbles. It redirects
// fetch on taken branches and freezes the pipeline while a memory access is
// outstanding. It also keeps saturating counters of stall and flush events.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   id_rs1/id_rs2            source registers of the instruction in ID
//   id_use_rs1/id_use_rs2    ID instruction actually reads that source
//   ex_valid/ex_wb_en/ex_is_load/ex_rd/ex_br_taken   EX-stage producer + branch
//   mem_valid/mem_wb_en/mem_rd                       MEM/WB-stage producer
//   mem_req/mem_ready        MEM-stage data access and its completion
//   stall_if/stall_id/stall_ex/flush_id/flush_ex     pipeline controls
//   fwd_a/fwd_b              operand select: 0 regfile, 1 EX, 2 MEM/WB
//   state                    current controller state (RUN/MEMWAIT/REDIRECT)
//   stall_cnt/flush_cnt      saturating event counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_wb_en,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_valid,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_pending;
    logic             w_next_pending;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Register r is produced by a valid writer in that stage; x0 never matches.
    function automatic logic f_match(input logic             valid,
                                     input logic             wb_en,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] r);
        return valid & wb_en & (rd == r) & (r != '0);
    endfunction

    logic w_ex_rs1, w_ex_rs2, w_mem_rs1, w_mem_rs2;
    logic w_load_use, w_memstall;
    logic w_take_branch, w_take_lu;

    assign w_ex_rs1  = f_match(ex_valid, ex_wb_en, ex_rd, id_rs1);
    assign w_ex_rs2  = f_match(ex_valid, ex_wb_en, ex_rd, id_rs2);
    assign w_mem_rs1 = f_match(mem_valid, mem_wb_en, mem_rd, id_rs1);
    assign w_mem_rs2 = f_match(mem_valid, mem_wb_en, mem_rd, id_rs2);

    assign w_load_use = ex_is_load & ((id_use_rs1 & w_ex_rs1) | (id_use_rs2 & w_ex_rs2));
    assign w_memstall = mem_req & ~mem_ready;

    // A branch held in EX is acted on (and counted) only in the cycle the
    // pipeline is free to move. In REDIRECT the EX slot holds a killed bubble.
    assign w_take_branch = ~w_memstall & ex_br_taken & (r_state != REDIRECT);

    // Load-use is irrelevant while a redirect is still owed. The ID
    // instruction is then wrong-path and about to be flushed.
    assign w_take_lu = ~w_memstall & ~ex_br_taken & w_load_use
                     & (r_state != REDIRECT)
                     & ~((r_state == MEMWAIT) & r_pending);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_next_pending;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state   = r_state;
        w_next_pending = r_pending;
        if (w_memstall) begin
            w_next_state   = MEMWAIT;
            // A redirect interrupted by a memory stall must still happen later.
            w_next_pending = r_pending | (r_state == REDIRECT);
        end else begin
            w_next_pending = 1'b0;
            unique case (r_state)
                REDIRECT: w_next_state = RUN;
                MEMWAIT:  w_next_state = (ex_br_taken || r_pending) ? REDIRECT : RUN;
                // The unused encoding is recovered as RUN.
                default:  w_next_state = ex_br_taken ? REDIRECT : RUN;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output logic (Mealy: depends on state and current hazards)
    // ---------------------------------------------------------------------
    logic [1:0] w_fwd_a, w_fwd_b;

    always_comb begin
        w_fwd_a = 2'd0;
        if (w_ex_rs1 && !ex_is_load) w_fwd_a = 2'd1;
        else if (w_mem_rs1)          w_fwd_a = 2'd2;
        w_fwd_b = 2'd0;
        if (w_ex_rs2 && !ex_is_load) w_fwd_b = 2'd1;
        else if (w_mem_rs2)          w_fwd_b = 2'd2;
    end

    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        fwd_a    = 2'd0;
        fwd_b    = 2'd0;
        // NOTE: these outputs are combinational from the inputs, so they are
        // gated by rst_n to be quiet for the whole reset, not just after an edge.
        if (rst_n) begin
            fwd_a = w_fwd_a;
            fwd_b = w_fwd_b;
            if (w_memstall) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else if (w_take_branch) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (r_state == REDIRECT) begin
                // Kill the wrong-path instruction fetched during the branch cycle.
                flush_id = 1'b1;
            end else if (w_take_lu) begin
                // Hold IF/ID one cycle and inject a bubble into EX.
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_if && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_take_branch && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
